// File: rtl/proc_multicycle.sv
// rtl/proc_multicycle.sv - multi-cycle core (FETCH/DECODE/EXEC/MEM/WB) with req/ack memory ports
// Optional WB trace outputs (trc_we/trc_rd/trc_data) enabled by defining PROC_WB_TRACE_EN.
module proc_multicycle #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int NREG   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              retire,
  output logic              halted,
`ifdef PROC_WB_TRACE_EN
  output logic              illegal,
  output logic              trc_we,
  output logic [3:0]        trc_rd,
  output logic [DATA_W-1:0] trc_data
`else
  output logic              illegal
`endif
);
  localparam int SHW = $clog2(DATA_W);
  localparam logic [4:0] OP_AR   = 5'b00000;
  localparam logic [4:0] OP_T    = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_ST   = 5'b00011;
  localparam logic [4:0] OP_BZ   = 5'b00100;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_pc;
  logic [ADDR_W-1:0]        r_addr;
  logic [31:0]              r_instr;
  logic [DATA_W-1:0]        r_regs [NREG];
  logic [DATA_W-1:0]        r_a;
  logic [DATA_W-1:0]        r_b;
  logic [DATA_W-1:0]        r_res;
  logic                     r_halted;
  logic                     r_illegal;

  logic [4:0]               w_op;
  logic [3:0]               w_func;
  logic [3:0]               w_rd;
  logic signed [DATA_W-1:0] w_imm19;
  logic signed [DATA_W-1:0] w_imm15;
  logic [DATA_W-1:0]        w_alu;
  logic                     w_legal;
  logic [ADDR_W-1:0]        w_pc_inc;

  assign w_op     = r_instr[31:27];
  assign w_func   = r_instr[26:23];
  assign w_imm19  = DATA_W'($signed(r_instr[18:0]));
  assign w_imm15  = DATA_W'($signed(r_instr[14:0]));
  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_comb begin
    w_legal = 1'b0;
    w_rd    = r_instr[18:15];
    case (w_op)
      OP_AR: begin
        w_legal = ~w_func[3];
        w_rd    = r_instr[14:11];
      end
      OP_T: begin
        w_legal = 1'b1;
        w_rd    = r_instr[22:19];
      end
      OP_LD, OP_ST, OP_BZ, OP_HALT: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // Shift amount uses only the low SHW bits of rs2.
  always_comb begin
    w_alu = '0;
    case (w_func[2:0])
      3'd0: w_alu = r_a + r_b;
      3'd1: w_alu = r_a - r_b;
      3'd2: w_alu = r_a & r_b;
      3'd3: w_alu = r_a | r_b;
      3'd4: w_alu = r_a ^ r_b;
      3'd5: w_alu = r_a << r_b[SHW-1:0];
      3'd6: w_alu = r_a >> r_b[SHW-1:0];
      default: w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state   <= S_FETCH;
      r_pc      <= '0;
      r_addr    <= '0;
      r_instr   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a <= r_regs[r_instr[22:19]];
          r_b <= r_regs[r_instr[18:15]];
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_halted  <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (w_op)
            OP_HALT: begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
            OP_BZ: begin
              r_pc    <= (r_a == '0) ? w_pc_inc + ADDR_W'(w_imm19) : w_pc_inc;
              r_state <= S_FETCH;
            end
            OP_LD, OP_ST: begin
              r_addr  <= ADDR_W'(r_a + w_imm15);
              r_state <= S_MEM;
            end
            OP_T: begin
              r_res   <= w_imm19;
              r_state <= S_WB;
            end
            default: begin
              r_res   <= w_alu;
              r_state <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (w_op == OP_LD) begin
              r_res   <= dmem_rdata;
              r_state <= S_WB;
            end else begin
              r_pc    <= w_pc_inc;
              r_state <= S_FETCH;
            end
          end
        end
        S_WB: begin
          // r0 is never written, so it keeps its reset value of zero.
          if (w_rd != 4'd0) r_regs[w_rd] <= r_res;
          r_pc    <= w_pc_inc;
          r_state <= S_FETCH;
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign imem_req   = (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = (w_op == OP_ST);
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_b;
  assign retire     = (r_state == S_WB) ||
                      ((r_state == S_EXEC) && (w_op == OP_BZ)) ||
                      ((r_state == S_MEM) && dmem_ack && (w_op == OP_ST));
  assign halted     = r_halted;
  assign illegal    = r_illegal;

`ifdef PROC_WB_TRACE_EN
  assign trc_we   = (r_state == S_WB);
  assign trc_rd   = w_rd;
  assign trc_data = r_res;
`endif

endmodule

// File: tb/tb_proc_multicycle.sv
// tb/tb_proc_multicycle.sv - scoreboard bench: ISA-level reference model vs fetch/data/retire traffic
module tb_proc_multicycle;
  logic        CLK;
  logic        RESET;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        retire;
  logic        halted;
  logic        illegal;

  proc_multicycle dut (
    .CLK(CLK), .RESET(RESET),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .retire(retire), .halted(halted), .illegal(illegal)
  );

  typedef struct {int addr; int lat;} fe_t;
  typedef struct {bit we; logic [15:0] addr; logic [31:0] wdata;} dm_t;

  localparam logic [31:0] HALT_I = {5'h1f, 27'd0};

  fe_t         q_fe[$];
  dm_t         q_dm[$];
  logic [31:0] prog [0:255];
  logic [31:0] env_mem [int];
  logic [31:0] ref_mem [int];
  int          exp_retire, act_retire, n_cmp, n_fail;
  bit          exp_illegal;
  bit          zero_wait, stale_ack;
  int          dm_force, last_ld_cnt, cyc, cur_lat, fetch_cyc, dm_cnt;
  logic [15:0] dm_addr0;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_init(input int a);
    logic [31:0] t;
    t = a;
    return (t * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] enc_t(input int rd, input int imm);
    return {5'd1, 4'd0, rd[3:0], imm[18:0]};
  endfunction
  function automatic logic [31:0] enc_ar(input int fn, input int rs1, input int rs2, input int rd);
    return {5'd0, fn[3:0], rs1[3:0], rs2[3:0], rd[3:0], 11'd0};
  endfunction
  function automatic logic [31:0] enc_ld(input int rd, input int rs1, input int imm);
    return {5'd2, 4'd0, rs1[3:0], rd[3:0], imm[14:0]};
  endfunction
  function automatic logic [31:0] enc_st(input int rs, input int rs1, input int imm);
    return {5'd3, 4'd0, rs1[3:0], rs[3:0], imm[14:0]};
  endfunction
  function automatic logic [31:0] enc_bz(input int rs1, input int off);
    return {5'd4, 4'd0, rs1[3:0], off[18:0]};
  endfunction

  // Architectural interpreter: runs the program and records the expected bus traffic.
  task automatic model_run();
    logic [31:0] r [16];
    logic [15:0] pc, ea;
    logic [31:0] ins, a, b, v, s19, s15;
    bit done;
    fe_t f;
    dm_t d;
    q_fe.delete(); q_dm.delete(); ref_mem.delete();
    exp_retire = 0; exp_illegal = 0;
    foreach (r[i]) r[i] = '0;
    pc = '0; done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      ins = prog[pc[7:0]];
      a = r[ins[22:19]];
      b = r[ins[18:15]];
      s19 = {{13{ins[18]}}, ins[18:0]};
      s15 = {{17{ins[14]}}, ins[14:0]};
      f.addr = int'(pc); f.lat = 0;
      case (ins[31:27])
        5'd0: begin
          if (ins[26]) begin exp_illegal = 1; done = 1; end
          else begin
            case (ins[25:23])
              3'd0: v = a + b;
              3'd1: v = a - b;
              3'd2: v = a & b;
              3'd3: v = a | b;
              3'd4: v = a ^ b;
              3'd5: v = a << b[4:0];
              3'd6: v = a >> b[4:0];
              default: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            endcase
            if (ins[14:11] != 0) r[ins[14:11]] = v;
            f.lat = 4; pc = pc + 1;
          end
        end
        5'd1: begin
          if (ins[22:19] != 0) r[ins[22:19]] = s19;
          f.lat = 4; pc = pc + 1;
        end
        5'd2: begin
          ea = a[15:0] + s15[15:0];
          d.we = 0; d.addr = ea; d.wdata = '0; q_dm.push_back(d);
          v = ref_mem.exists(int'(ea)) ? ref_mem[int'(ea)] : mem_init(int'(ea));
          if (ins[18:15] != 0) r[ins[18:15]] = v;
          f.lat = 5; pc = pc + 1;
        end
        5'd3: begin
          ea = a[15:0] + s15[15:0];
          d.we = 1; d.addr = ea; d.wdata = b; q_dm.push_back(d);
          ref_mem[int'(ea)] = b;
          f.lat = 4; pc = pc + 1;
        end
        5'd4: begin
          f.lat = 3;
          pc = (a == 0) ? pc + 16'd1 + s19[15:0] : pc + 16'd1;
        end
        5'd31: done = 1;
        default: begin exp_illegal = 1; done = 1; end
      endcase
      q_fe.push_back(f);
      if (f.lat != 0) exp_retire++;
    end
  endtask

  initial begin : imem_resp
    int iw;
    imem_ack = 0; imem_rdata = '0; iw = -1;
    forever begin
      @(negedge CLK);
      if (imem_req) begin
        if (iw < 0) iw = zero_wait ? 0 : int'($urandom_range(0, 3));
        if (iw == 0) begin
          imem_ack = 1; imem_rdata = prog[imem_addr[7:0]]; iw = -1;
        end else begin
          imem_ack = 0; iw--;
        end
      end else begin
        imem_ack = 0; iw = -1;
      end
    end
  end

  initial begin : dmem_resp
    int dw;
    dmem_ack = 0; dmem_rdata = '0; dw = -1;
    forever begin
      @(negedge CLK);
      if (stale_ack) begin
        dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF; stale_ack = 0; dw = -1;
      end else if (dmem_req) begin
        if (dw < 0) dw = (dm_force > 0) ? dm_force - 1 : (zero_wait ? 0 : int'($urandom_range(0, 3)));
        if (dw == 0) begin
          dmem_ack = 1;
          if (dmem_we) env_mem[int'(dmem_addr)] = dmem_wdata;
          else dmem_rdata = env_mem.exists(int'(dmem_addr)) ? env_mem[int'(dmem_addr)] : mem_init(int'(dmem_addr));
          dw = -1;
        end else begin
          dmem_ack = 0; dw--;
        end
      end else begin
        dmem_ack = 0; dw = -1;
      end
    end
  end

  initial begin : monitor
    fe_t f;
    dm_t d;
    cyc = 0; cur_lat = 0; dm_cnt = 0; fetch_cyc = 0;
    forever begin
      @(negedge CLK); #2;
      cyc++;
      if (!RESET) begin
        cur_lat = 0; dm_cnt = 0;
      end else begin
        if (imem_req && imem_ack) begin
          if (q_fe.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL fetch_extra: fetch of %0h with nothing expected", imem_addr);
          end else begin
            f = q_fe.pop_front();
            chk("fetch_addr", imem_addr, f.addr);
            cur_lat = f.lat; fetch_cyc = cyc;
          end
        end
        if (dmem_req) begin
          if (dm_cnt == 0) dm_addr0 = dmem_addr;
          dm_cnt++;
          if (dmem_ack) begin
            if (q_dm.size() == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL dmem_extra: access at %0h with nothing expected", dmem_addr);
            end else begin
              d = q_dm.pop_front();
              chk("dmem_we", dmem_we, d.we);
              chk("dmem_addr", dmem_addr, d.addr);
              chk("dmem_addr_stable", dmem_addr, dm_addr0);
              if (d.we) chk("dmem_wdata", dmem_wdata, d.wdata);
              if (!d.we) last_ld_cnt = dm_cnt;
            end
            dm_cnt = 0;
          end
        end
        if (retire) begin
          act_retire++;
          if (cur_lat == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL retire_spurious: retire at cycle %0d with no instruction due", cyc);
          end else if (zero_wait && dm_force == 0) begin
            chk("latency", cyc - fetch_cyc + 1, cur_lat);
          end
          cur_lat = 0;
        end
      end
    end
  end

  task automatic finish_run();
    for (int i = 0; i < 3000 && !halted; i++) @(negedge CLK);
    chk("halted", halted, 1);
    repeat (3) begin
      @(negedge CLK); #3;
      chk("idle_after_halt", {imem_req, dmem_req, retire}, 0);
    end
    chk("illegal_flag", illegal, exp_illegal);
    chk("retire_count", act_retire, exp_retire);
    chk("fetch_left", q_fe.size(), 0);
    chk("dmem_left", q_dm.size(), 0);
  endtask

  task automatic start_run(input bit zw);
    @(negedge CLK);
    RESET = 0; zero_wait = zw; env_mem.delete();
    model_run(); act_retire = 0; last_ld_cnt = 0;
    @(negedge CLK);
    RESET = 1; #1;
    chk("rst_imem_req", imem_req, 1);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_retire", retire, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) prog[i] = HALT_I;
  endtask

  task automatic gen_random(input int len);
    int rs1;
    fill_halt();
    for (int i = 0; i < len; i++) begin
      rs1 = $urandom_range(0, 1) ? 0 : int'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: prog[i] = enc_t($urandom_range(0, 15), $urandom);
        1, 2: prog[i] = enc_ar($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        3: prog[i] = enc_ld($urandom_range(0, 15), rs1, $urandom_range(0, 15));
        4: prog[i] = enc_st($urandom_range(0, 15), rs1, $urandom_range(0, 15));
        default: prog[i] = enc_bz($urandom_range(0, 15), $urandom_range(0, 3));
      endcase
    end
  endtask

  initial begin : seq
    RESET = 0; zero_wait = 1; stale_ack = 0; dm_force = 0;
    n_cmp = 0; n_fail = 0;
    repeat (2) @(negedge CLK);

    fill_halt();
    prog[0]  = enc_t(1, 5);
    prog[1]  = enc_t(2, -3);
    prog[2]  = enc_ar(0, 1, 2, 3);
    prog[3]  = enc_st(3, 0, 7);
    prog[4]  = enc_ld(4, 0, 7);
    prog[5]  = enc_st(4, 0, 8);
    prog[6]  = enc_bz(0, 3);
    prog[10] = enc_bz(0, -2);
    prog[9]  = enc_bz(0, 2);
    prog[12] = enc_bz(1, -2);
    prog[13] = enc_t(5, -1);
    prog[14] = enc_t(6, 1);
    prog[15] = enc_ar(7, 5, 6, 7);
    prog[16] = enc_st(7, 0, 9);
    prog[17] = enc_t(8, 33);
    prog[18] = enc_ar(5, 1, 8, 9);
    prog[19] = enc_st(9, 0, 10);
    prog[20] = enc_ar(0, 1, 1, 0);
    prog[21] = enc_st(0, 0, 11);
    start_run(1);
    finish_run();
    chk("add_result_mem7", env_mem[7], 2);
    chk("ld_result_mem8", env_mem[8], 2);
    chk("slt_result_mem9", env_mem[9], 1);
    chk("sll33_result_mem10", env_mem[10], 10);
    chk("r0_write_mem11", env_mem[11], 0);

    dm_force = 3;
    start_run(0);
    finish_run();
    chk("ld_req_cycles", last_ld_cnt, 3);
    dm_force = 0;

    fill_halt();
    prog[0] = enc_t(1, 1);
    prog[1] = {5'b01010, 27'd0};
    start_run(1);
    finish_run();

    fill_halt();
    prog[0] = enc_ar(9, 1, 1, 1);
    start_run(0);
    finish_run();

    for (int k = 0; k < 6; k++) begin
      gen_random(40);
      start_run(k % 2 == 0);
      finish_run();
    end

    fill_halt();
    prog[0] = enc_t(1, 'h55);
    prog[1] = enc_ld(2, 0, 5);
    prog[2] = enc_st(2, 0, 6);
    prog[3] = enc_st(1, 0, 12);
    dm_force = 20;
    start_run(0);
    for (int w = 0; w < 200 && !dmem_req; w++) @(negedge CLK);
    chk("mid_req_seen", dmem_req, 1);
    @(negedge CLK);
    RESET = 0;
    @(posedge CLK); #1;
    chk("rst_abandon", dmem_req, 0);
    stale_ack = 1; dm_force = 0;
    model_run(); act_retire = 0;
    @(negedge CLK);
    RESET = 1; #3;
    chk("stale_ack_no_req", {dmem_ack, dmem_req}, 2'b10);
    finish_run();
    chk("rerun_mem6", env_mem[6], mem_init(5));
    chk("rerun_mem12", env_mem[12], 'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
